data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-requester (CPU, loader) arbiter in front of a single-port
// data memory. One access per cycle, response one cycle after grant. Contended
// cycles are round-robin, except that the loader may lock a burst of up to
// MAX_BURST consecutive grants during which it has absolute priority.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // CPU port
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  // Loader port
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic                  ldr_lock,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  ldr_gnt,
  output logic                  ldr_ack,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  // Memory port
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Arbiter state encoding
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Requester identity used by last_gnt and the ack owner register
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  // Burst length limit in counter width (legal range 2..255 fits in 8 bits)
  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  // Arbitration state
  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [7:0] r_burst_cnt;
  logic [7:0] w_burst_cnt_nxt;
  logic [7:0] w_burst_cnt_inc;
  logic       r_last_gnt;
  logic       w_last_gnt_nxt;

  // Response pipeline: which requester owns the ack this cycle, and whether it was a read
  logic       r_ack_vld;
  logic       r_ack_owner;
  logic       r_ack_rd;

  // Combinational grants
  logic       w_cpu_gnt;
  logic       w_ldr_gnt;
  logic       w_any_gnt;
  logic       w_gnt_we;

  // 8-bit saturating increment for the burst counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Grant selection: burst gives the loader absolute priority, otherwise
  // a lone requester wins and a contended cycle goes to whoever did not win last.
  // Grants are forced low while reset is asserted.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ldr_gnt = 1'b0;
    if (rst) begin
      if (r_state == ST_BURST) begin
        w_ldr_gnt = ldr_req;
        w_cpu_gnt = cpu_req & ~ldr_req;
      end else if (cpu_req && ldr_req) begin
        if (r_last_gnt == OWN_LDR) begin
          w_cpu_gnt = 1'b1;
        end else begin
          w_ldr_gnt = 1'b1;
        end
      end else begin
        w_cpu_gnt = cpu_req;
        w_ldr_gnt = ldr_req;
      end
    end
  end

  assign w_any_gnt       = w_cpu_gnt | w_ldr_gnt;
  assign w_burst_cnt_inc = sat_inc8(r_burst_cnt);

  // Next-state logic for the ARB/BURST machine, burst counter and round-robin pointer.
  always_comb begin
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    w_last_gnt_nxt  = r_last_gnt;

    // Round-robin pointer follows every grant
    if (w_cpu_gnt) begin
      w_last_gnt_nxt = OWN_CPU;
    end else if (w_ldr_gnt) begin
      w_last_gnt_nxt = OWN_LDR;
    end

    if (r_state == ST_ARB) begin
      // A lock request only takes effect on a loader grant; the grant itself is the first of the burst
      if (w_ldr_gnt && ldr_lock) begin
        w_state_nxt     = ST_BURST;
        w_burst_cnt_nxt = 8'd1;
      end
    end else begin
      if (!ldr_req || !ldr_lock) begin
        // Loader released the lock or went idle: back to fair arbitration
        w_state_nxt     = ST_ARB;
        w_burst_cnt_nxt = 8'd0;
      end else if (w_ldr_gnt) begin
        if (w_burst_cnt_inc >= MAX_CNT) begin
          // Burst limit reached; pointing last_gnt at the loader hands the CPU the next contention
          w_state_nxt     = ST_ARB;
          w_burst_cnt_nxt = 8'd0;
          w_last_gnt_nxt  = OWN_LDR;
        end else begin
          w_burst_cnt_nxt = w_burst_cnt_inc;
        end
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_ARB;
      r_burst_cnt <= 8'd0;
      r_last_gnt  <= OWN_LDR;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_last_gnt  <= w_last_gnt_nxt;
    end
  end

  // Mux of the write-enable of whichever requester holds the grant
  always_comb begin
    w_gnt_we = 1'b0;
    if (w_cpu_gnt) begin
      w_gnt_we = cpu_we;
    end else if (w_ldr_gnt) begin
      w_gnt_we = ldr_we;
    end
  end

  // Owner/ack pipeline: one-cycle delayed record of the grant; reset drops any pending ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack_vld   <= 1'b0;
      r_ack_owner <= OWN_CPU;
      r_ack_rd    <= 1'b0;
    end else begin
      r_ack_vld   <= w_any_gnt;
      r_ack_owner <= w_ldr_gnt ? OWN_LDR : OWN_CPU;
      r_ack_rd    <= w_any_gnt & ~w_gnt_we;
    end
  end

  // Memory command follows the granted requester; address/data default to the CPU side when idle
  assign mem_en    = w_any_gnt;
  assign mem_we    = w_gnt_we;
  assign mem_addr  = w_ldr_gnt ? ldr_addr  : cpu_addr;
  assign mem_wdata = w_ldr_gnt ? ldr_wdata : cpu_wdata;

  // Requester-facing outputs
  assign cpu_gnt   = w_cpu_gnt;
  assign ldr_gnt   = w_ldr_gnt;
  assign cpu_stall = cpu_req & ~w_cpu_gnt;
  assign cpu_ack   = r_ack_vld & (r_ack_owner == OWN_CPU);
  assign ldr_ack   = r_ack_vld & (r_ack_owner == OWN_LDR);
  assign cpu_rdata = (cpu_ack && r_ack_rd) ? mem_rdata : '0;
  assign ldr_rdata = (ldr_ack && r_ack_rd) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the arbiter and a model copy of the memory contents.
module tb_data_mem_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_ack, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          ldr_req, ldr_we, ldr_lock;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_gnt, ldr_ack;
  logic [DW-1:0] ldr_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i));
  endfunction

  // Memory attached to the DUT command port: one-cycle read latency
  logic          mem_ready = 1'b0;
  logic [31:0]   mem [256];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [31:0] ref_mem [256];
  bit          m_burst;
  int          m_run;
  bit          m_last_ldr;
  bit          p_vld, p_ldr, p_rd;
  logic [31:0] p_dat;
  bit          e_cg, e_lg;
  bit          obs_cg, obs_lg, obs_stall;
  bit          c_act, l_act;

  task automatic model_reset();
    m_burst = 0; m_run = 0; m_last_ldr = 1; p_vld = 0; p_ldr = 0; p_rd = 0; p_dat = '0;
    obs_cg = 0; obs_lg = 0; obs_stall = 0; c_act = 0; l_act = 0;
  endtask

  task automatic model_grant(output bit cg, output bit lg);
    cg = 0; lg = 0;
    if (m_burst) begin
      lg = ldr_req;
      cg = cpu_req && !ldr_req;
    end else if (cpu_req && ldr_req) begin
      cg = m_last_ldr;
      lg = !m_last_ldr;
    end else begin
      cg = cpu_req;
      lg = ldr_req;
    end
  endtask

  task automatic model_commit();
    p_vld = e_cg | e_lg;
    p_ldr = e_lg;
    p_rd  = 0;
    if (e_cg) begin
      p_rd  = !cpu_we;
      p_dat = ref_mem[cpu_addr[7:0]];
      if (cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
    end else if (e_lg) begin
      p_rd  = !ldr_we;
      p_dat = ref_mem[ldr_addr[7:0]];
      if (ldr_we) ref_mem[ldr_addr[7:0]] = ldr_wdata;
    end
    if (e_cg || e_lg) m_last_ldr = e_lg;
    if (!m_burst) begin
      if (e_lg && ldr_lock) begin m_burst = 1; m_run = 1; end
    end else if (!ldr_req || !ldr_lock) begin
      m_burst = 0; m_run = 0;
    end else begin
      m_run++;
      if (m_run >= MAXB) begin m_burst = 0; m_run = 0; end
    end
  endtask

  // One clock cycle: inputs already driven; check at the falling edge, then advance
  task automatic step();
    @(negedge clk);
    model_grant(e_cg, e_lg);
    obs_cg = cpu_gnt; obs_lg = ldr_gnt; obs_stall = cpu_stall;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
    chk("ldr_gnt", 32'(ldr_gnt), 32'(e_lg));
    chk("one_gnt", 32'(cpu_gnt & ldr_gnt), 32'd0);
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~e_cg));
    chk("mem_en", 32'(mem_en), 32'(e_cg | e_lg));
    chk("mem_we", 32'(mem_we), 32'(e_cg ? cpu_we : (e_lg ? ldr_we : 1'b0)));
    if (e_cg || e_lg) begin
      chk("mem_addr", mem_addr, e_lg ? ldr_addr : cpu_addr);
      chk("mem_wdata", mem_wdata, e_lg ? ldr_wdata : cpu_wdata);
    end
    chk("cpu_ack", 32'(cpu_ack), 32'(p_vld && !p_ldr));
    chk("ldr_ack", 32'(ldr_ack), 32'(p_vld && p_ldr));
    if (p_vld && p_rd) begin
      if (p_ldr) chk("ldr_rdata", ldr_rdata, p_dat);
      else       chk("cpu_rdata", cpu_rdata, p_dat);
    end
    model_commit();
    @(posedge clk); #1;
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ldr(input bit req, input bit we, input bit lock, input logic [31:0] a,
                         input logic [31:0] d);
    ldr_req = req; ldr_we = we; ldr_lock = lock; ldr_addr = a; ldr_wdata = d;
  endtask

  // Assert reset mid-cycle, check outputs are forced off, release away from the clock edge
  task automatic apply_reset();
    rst = 1'b0;
    #1;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_ldr_gnt", 32'(ldr_gnt), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_ldr_ack", 32'(ldr_ack), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_ldr_rdata", ldr_rdata, 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'(cpu_req));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    set_cpu(0, 0, 0, 0);
    set_ldr(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive_random(input int pc, input int pl, input int plk);
    if (obs_cg) c_act = 0;
    if (obs_lg) l_act = 0;
    if (!c_act && int'($urandom_range(99)) < pc) begin
      c_act = 1;
      set_cpu(1, 1'($urandom_range(1)), 32'($urandom_range(15)), $urandom);
    end
    cpu_req = c_act;
    if (!l_act && int'($urandom_range(99)) < pl) begin
      l_act = 1;
      ldr_we = 1'($urandom_range(1)); ldr_addr = 32'($urandom_range(15)); ldr_wdata = $urandom;
    end
    ldr_req  = l_act;
    ldr_lock = (int'($urandom_range(99)) < plk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1'b0;
    set_cpu(1, 0, 0, 0);
    set_ldr(1, 0, 1, 0, 0);
    model_reset();
    #1;
    apply_reset();

    // CPU read of 0x10 right after reset release
    set_cpu(1, 0, 32'h10, 0);
    step();
    chk("r034_gnt", 32'(obs_cg), 32'd1);
    chk("r034_stall", 32'(obs_stall), 32'd0);
    chk("r034_ack", 32'(cpu_ack), 32'd1);
    chk("r034_rdata", cpu_rdata, 32'hDEADBEEF);
    set_cpu(0, 0, 0, 0);
    step();

    // Both requesting, unlocked: strict alternation starting with the CPU
    apply_reset();
    set_cpu(1, 0, 32'h1, 0);
    set_ldr(1, 0, 0, 32'h2, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("r035_cpu", 32'(obs_cg), 32'(k % 2 == 0));
      chk("r035_ldr", 32'(obs_lg), 32'(k % 2 == 1));
    end

    // Locked burst of MAX_BURST grants with the CPU waiting
    apply_reset();
    set_cpu(1, 0, 32'h3, 0);
    step();
    set_ldr(1, 0, 1, 32'h5, 0);
    for (int k = 0; k < MAXB; k++) begin
      step();
      chk("r036_ldr", 32'(obs_lg), 32'd1);
      chk("r036_stall", 32'(obs_stall), 32'd1);
    end
    step();
    chk("r036_cpu", 32'(obs_cg), 32'd1);

    // Lock dropped after 3 grants
    apply_reset();
    set_cpu(1, 0, 32'h3, 0);
    step();
    set_ldr(1, 0, 1, 32'h6, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("r037_ldr", 32'(obs_lg), 32'd1);
    end
    ldr_lock = 0;
    step();
    step();
    chk("r037_cpu", 32'(obs_cg), 32'd1);

    // CPU write then loader read of the same word
    apply_reset();
    set_cpu(1, 1, 32'h20, 32'h55);
    step();
    chk("r038_cgnt", 32'(obs_cg), 32'd1);
    set_cpu(0, 0, 0, 0);
    set_ldr(1, 0, 0, 32'h20, 0);
    chk("r038_cack", 32'(cpu_ack), 32'd1);
    step();
    chk("r038_lgnt", 32'(obs_lg), 32'd1);
    chk("r038_lack", 32'(ldr_ack), 32'd1);
    chk("r038_cack_off", 32'(cpu_ack), 32'd0);
    chk("r038_rdata", ldr_rdata, 32'h55);
    set_ldr(0, 0, 0, 0, 0);
    step();

    // Reset in the middle of a burst with a read ack pending
    apply_reset();
    set_cpu(1, 0, 32'h3, 0);
    step();
    set_ldr(1, 0, 1, 32'h7, 0);
    for (int k = 0; k < 3; k++) step();
    chk("r039_pending", 32'(ldr_ack), 32'd1);
    apply_reset();
    chk("r039_noack_l", 32'(ldr_ack), 32'd0);
    chk("r039_noack_c", 32'(cpu_ack), 32'd0);
    set_cpu(1, 0, 32'h8, 0);
    set_ldr(1, 0, 1, 32'h9, 0);
    step();
    chk("r039_cpu", 32'(obs_cg), 32'd1);

    // Randomized traffic in phases of varying load and lock density
    for (int ph = 0; ph < 8; ph++) begin
      int pc, pl, plk;
      pc  = int'($urandom_range(30, 100));
      pl  = int'($urandom_range(30, 100));
      plk = int'($urandom_range(0, 100));
      for (int k = 0; k < 200; k++) begin
        drive_random(pc, pl, plk);
        step();
        if ($urandom_range(249) == 0) apply_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
